// File: rtl/adder_pkg.sv
// Shared width and word type for the ripple-carry adder.
// Pure declarations; no latency.
// No flow control involved.
package adder_pkg;

   localparam int ADDER_WIDTH = 32;

   typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage

// File: rtl/full_32bit_adder_if.sv
// Operand/result bundle for full_32bit_adder; the optional ovf signal exists only
// when FULL_32BIT_ADDER_OVF_EN is defined.
// master = operand source / result sink, slave = the adder. No ready: sink always accepts.
interface full_32bit_adder_if
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
);

   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef FULL_32BIT_ADDER_OVF_EN
   logic             ovf;

   modport master (output in_valid, a, b, cin, input out_valid, sum, cout, ovf);
   modport slave  (input in_valid, a, b, cin, output out_valid, sum, cout, ovf);
`else
   modport master (output in_valid, a, b, cin, input out_valid, sum, cout);
   modport slave  (input in_valid, a, b, cin, output out_valid, sum, cout);
`endif

endinterface

// File: rtl/full_adder.sv
// Single-bit full-adder cell, the link of the ripple chain.
// Purely combinational, zero cycles.
// No flow control.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_32bit_adder.sv
// Registered unsigned WIDTH-bit add with carry in/out; FULL_32BIT_ADDER_OVF_EN adds signed ovf.
// Latency 1 cycle, one add per cycle.
// No backpressure; in_valid=0 drops out_valid and freezes sum/cout(/ovf).
module full_32bit_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   full_32bit_adder_if.slave bus
);

   // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_c;

   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             valid_q;

   assign carry[0] = bus.cin;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_cell
         full_adder u_fa (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .cin  (carry[i]),
            .sum  (sum_c[i]),
            .cout (carry[i+1])
         );
      end
   endgenerate

   // Valid flag tracks in_valid one cycle later; reset kills anything in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
      end
   end

   // Result registers load only on a valid input and otherwise keep the last result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (bus.in_valid) begin
         sum_q  <= sum_c;
         cout_q <= carry[WIDTH];
      end
   end

   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.out_valid = valid_q;

`ifdef FULL_32BIT_ADDER_OVF_EN
   logic ovf_q;

   // Signed overflow: carry into the sign bit disagrees with carry out of it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (bus.in_valid) begin
         ovf_q <= carry[WIDTH] ^ carry[WIDTH-1];
      end
   end

   assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_32bit_adder.sv
// Self-checking bench for full_32bit_adder: directed cases plus randomized
// back-to-back traffic compared against an arithmetic reference model.
// Inputs change and outputs are sampled on the falling edge.
module tb_full_32bit_adder;
   import adder_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   full_32bit_adder_if #(.WIDTH(ADDER_WIDTH)) bus ();

   full_32bit_adder #(.WIDTH(ADDER_WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      word_t a;
      word_t b;
      logic  c;
      word_t s;
      logic  co;
      logic  ov;
   } vec_t;

   // Reference: plain wide arithmetic, result is {cout, sum}
   function automatic logic [ADDER_WIDTH:0] ref_add(word_t x, word_t y, logic c);
      logic [63:0] t;
      t = 64'(x) + 64'(y) + 64'(c);
      return t[ADDER_WIDTH:0];
   endfunction

`ifdef FULL_32BIT_ADDER_OVF_EN
   // Reference: signed result falls outside the two's-complement range
   function automatic logic ref_ovf(word_t x, word_t y, logic c);
      longint s;
      longint lim;
      lim = longint'(1) <<< (ADDER_WIDTH - 1);
      s   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
      return (s >= lim) || (s < -lim);
   endfunction
`endif

   task automatic put(word_t x, word_t y, logic c, logic v);
      bus.a        = x;
      bus.b        = y;
      bus.cin      = c;
      bus.in_valid = v;
   endtask

   function automatic word_t pick_operand();
      case ($urandom_range(0, 7))
         0:       return '1;
         1:       return '0;
         2:       return word_t'(32'h7FFF_FFFF);
         3:       return word_t'(32'h8000_0000);
         default: return word_t'($urandom());
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         put(word_t'($urandom()), word_t'($urandom()), 1'($urandom()), 1'b1);
         @(negedge clk);
         n_checks++;
         if ({bus.out_valid, bus.cout, bus.sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: got v=%b c=%b s=%h, want all zero",
                     i, bus.out_valid, bus.cout, bus.sum);
         end
      end
      put('0, '0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      put('1, '1, 1'b1, 1'b1);
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.cout, bus.sum} !== {1'b1, 1'b1, 32'hFFFF_FFFF}) begin
         n_fail++;
         $display("FAIL async_pre: got v=%b c=%b s=%h, want v=1 c=1 s=ffffffff",
                  bus.out_valid, bus.cout, bus.sum);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.out_valid, bus.cout, bus.sum} !== '0) begin
         n_fail++;
         $display("FAIL async_clear: got v=%b c=%b s=%h, want all zero before next edge",
                  bus.out_valid, bus.cout, bus.sum);
      end
      @(negedge clk);
      put('0, '0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   // Spec operand pairs with their known sums, issued back to back
   task automatic test_basic();
      vec_t v[$];
      v.push_back(vec_t'{32'd9642554,  32'd10756744,   1'b0, 32'd20399298,   1'b0, 1'b0});
      v.push_back(vec_t'{32'd1555844,  32'd1554,       1'b0, 32'd1557398,    1'b0, 1'b0});
      v.push_back(vec_t'{32'd46854,    32'd955235874,  1'b0, 32'd955282728,  1'b0, 1'b0});
      v.push_back(vec_t'{32'd1554,     32'd1046468054, 1'b0, 32'd1046469608, 1'b0, 1'b0});
      v.push_back(vec_t'{32'd15674,    32'd1357554,    1'b0, 32'd1373228,    1'b0, 1'b0});
      v.push_back(vec_t'{32'd15876464, 32'd15294,      1'b0, 32'd15891758,   1'b0, 1'b0});
      for (int i = 0; i <= v.size(); i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            if ({bus.out_valid, bus.cout, bus.sum} !== {1'b1, v[i-1].co, v[i-1].s}) begin
               n_fail++;
               $display("FAIL basic[%0d]: got v=%b c=%b s=%0d, want v=1 c=%b s=%0d",
                        i-1, bus.out_valid, bus.cout, bus.sum, v[i-1].co, v[i-1].s);
            end
         end
         if (i < v.size()) put(v[i].a, v[i].b, v[i].c, 1'b1);
         else              put('0, '0, 1'b0, 1'b0);
      end
   endtask

   // Wrap-around, carry-in propagation and signed-overflow corner cases
   task automatic test_carry();
      vec_t v[$];
      v.push_back(vec_t'{32'd2147945254, 32'd2147483648, 1'b0, 32'd461606,     1'b1, 1'b1});
      v.push_back(vec_t'{32'hFFFF_FFFF,  32'h0,          1'b1, 32'h0,          1'b1, 1'b0});
      v.push_back(vec_t'{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0});
      v.push_back(vec_t'{32'h0,          32'h0,          1'b0, 32'h0,          1'b0, 1'b0});
      v.push_back(vec_t'{32'h7FFF_FFFF,  32'h1,          1'b0, 32'h8000_0000,  1'b0, 1'b1});
      v.push_back(vec_t'{32'hFFFF_FFFF,  32'h1,          1'b0, 32'h0,          1'b1, 1'b0});
      for (int i = 0; i <= v.size(); i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            if ({bus.out_valid, bus.cout, bus.sum} !== {1'b1, v[i-1].co, v[i-1].s}) begin
               n_fail++;
               $display("FAIL carry[%0d]: got v=%b c=%b s=%h, want v=1 c=%b s=%h",
                        i-1, bus.out_valid, bus.cout, bus.sum, v[i-1].co, v[i-1].s);
            end
`ifdef FULL_32BIT_ADDER_OVF_EN
            n_checks++;
            if (bus.ovf !== v[i-1].ov) begin
               n_fail++;
               $display("FAIL ovf[%0d]: got %b, want %b", i-1, bus.ovf, v[i-1].ov);
            end
`endif
         end
         if (i < v.size()) put(v[i].a, v[i].b, v[i].c, 1'b1);
         else              put('0, '0, 1'b0, 1'b0);
      end
   endtask

   // One valid add, three idle cycles with changing operands, then a new add
   task automatic test_hold();
      word_t x, y;
      logic  c;
      logic [ADDER_WIDTH:0] r, r2;
      x = word_t'($urandom()) | word_t'(32'h8000_0001);
      y = word_t'($urandom()) | word_t'(32'h8000_0000);
      c = 1'b1;
      r = ref_add(x, y, c);
      @(negedge clk);
      put(x, y, c, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.out_valid, bus.cout, bus.sum} !== {(k == 0), r}) begin
            n_fail++;
            $display("FAIL hold[%0d]: got v=%b c=%b s=%h, want v=%b c=%b s=%h",
                     k, bus.out_valid, bus.cout, bus.sum, (k == 0), r[ADDER_WIDTH],
                     r[ADDER_WIDTH-1:0]);
         end
         put(word_t'($urandom()), word_t'($urandom()), 1'($urandom()), 1'b0);
      end
      x = word_t'($urandom_range(1, 1000));
      y = word_t'($urandom_range(1, 1000));
      r2 = ref_add(x, y, 1'b0);
      put(x, y, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.cout, bus.sum} !== {1'b1, r2}) begin
         n_fail++;
         $display("FAIL hold_resume: got v=%b c=%b s=%h, want v=1 c=%b s=%h",
                  bus.out_valid, bus.cout, bus.sum, r2[ADDER_WIDTH], r2[ADDER_WIDTH-1:0]);
      end
      put('0, '0, 1'b0, 1'b0);
   endtask

   // Random back-to-back traffic with random gaps, checked every cycle
   task automatic test_back_to_back();
      logic                 exp_v;
      logic [ADDER_WIDTH:0] exp_r;
      word_t                x, y;
      logic                 c, v;
`ifdef FULL_32BIT_ADDER_OVF_EN
      logic                 exp_o;
      exp_o = 1'b0;
`endif
      exp_v = 1'b0;
      exp_r = '0;
      for (int i = 0; i <= 300; i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            if ({bus.out_valid, bus.cout, bus.sum} !== {exp_v, exp_r}) begin
               n_fail++;
               $display("FAIL random[%0d]: got v=%b c=%b s=%h, want v=%b c=%b s=%h",
                        i, bus.out_valid, bus.cout, bus.sum, exp_v, exp_r[ADDER_WIDTH],
                        exp_r[ADDER_WIDTH-1:0]);
            end
`ifdef FULL_32BIT_ADDER_OVF_EN
            n_checks++;
            if (bus.ovf !== exp_o) begin
               n_fail++;
               $display("FAIL random_ovf[%0d]: got %b, want %b", i, bus.ovf, exp_o);
            end
`endif
         end
         if (i == 300) begin
            put('0, '0, 1'b0, 1'b0);
         end else begin
            x = pick_operand();
            y = pick_operand();
            c = 1'($urandom());
            v = (i == 0) || ($urandom_range(0, 3) != 0);
            put(x, y, c, v);
            exp_v = v;
            if (v) begin
               exp_r = ref_add(x, y, c);
`ifdef FULL_32BIT_ADDER_OVF_EN
               exp_o = ref_ovf(x, y, c);
`endif
            end
         end
      end
   endtask

   initial begin
      put('0, '0, 1'b0, 1'b0);
      test_reset();
      test_basic();
      test_carry();
      test_hold();
      test_async_reset();
      test_back_to_back();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
